r_bus_ram_responder: RTL and testbench
======================================

# r_bus_ram_responder

Read-port responder for the `r_busif` request/response bus: implements the `slave` end, serving word reads from an internal RAM filled through a simple synchronous write port. It sits behind any `r_busif` master, such as a table-lookup or coefficient-fetch unit, and turns a held `valid`/`addr` request into a one-cycle `ready` strobe with `data`, after a fixed, configurable pipeline latency.

## Interface
- `DATA_WIDTH`, 32, word width; must match the connected `r_busif`.
- `RAM_DEPTH`, 256, number of words; need not be a power of two. Address width `LB_RAM_DEPTH = $clog2(RAM_DEPTH)`.
- `READ_LATENCY`, 2, edges from request capture to `ready`; legal range 1..4.

- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: asynchronous active-low reset.
- `wr_en` in 1: write strobe.
- `wr_addr` in LB_RAM_DEPTH: write address.
- `wr_data` in DATA_WIDTH: write data.
- `rd_port` r_busif.slave: carries four signals.
  - `addr` in LB_RAM_DEPTH: read address.
  - `valid` in 1: read request.
  - `data` out DATA_WIDTH: read data.
  - `ready` out 1: response strobe.

## Operation
- FSM states:
  - IDLE: with `valid`=1 at an edge, capture `addr` and go to WAIT (L>1) or RESP (L=1).
  - WAIT: count L-1 edges, then go to RESP.
  - RESP: `ready`=1, `data` valid; the next edge always returns to IDLE, ignoring `valid`.
- Master rule: hold `valid` and `addr` stable until it samples `ready`=1, then drop or re-issue `valid`. A `valid` that drops before `ready` does not abort the request; the response is still issued.
- Write port is independent and can be used in every state. `wr_en` with `wr_addr` ≥ RAM_DEPTH is ignored.
- Read with captured `addr` ≥ RAM_DEPTH returns all-zero data, with normal latency and `ready`.
- Without bypass, the returned word is the RAM content at the capture edge. Writes on or after that edge are not visible in this response.
- `data` holds its last value outside RESP. It changes only on the edge that enters RESP.
- RAM contents are not reset. An unwritten word returns X in simulation.

## Timing
- Reset values: `ready`=0, `data`=0, state IDLE, latency counter 0.
- Reset asserted mid-request aborts it: no `ready` is produced, and the FSM is in IDLE after release.
- Latency: `valid` sampled at edge t0, so `ready`=1 during the cycle after edge t0+L-1, for L total edges including t0. For L=1, `ready` is high in the cycle right after capture.
- `ready` is high for exactly one cycle per accepted request.
- Throughput: one request per L+1 cycles. A new request can be captured on the first edge after RESP.
- `valid` high at the RESP→IDLE edge is not captured. Capture happens only at an edge where the state is IDLE.
- `ready` is never high while the state is IDLE or WAIT.

## Configuration
- `R_BUS_RAM_RESPONDER_BYPASS_EN` defined:
  - Any `wr_en` to the captured address on edges from t0 through the edge entering RESP is forwarded into the response.
  - If several such writes occur, the last one wins.
  - A write on the edge entering RESP is included.
- Not defined: no forwarding. The response is the RAM content at capture, as described above. This saves a comparator and a data mux.

## Test plan
- Reset, write then read:
  - While `n_rst`=0, `ready`=0 and `data`=0.
  - Write 0xDEADBEEF to addr 5, then request addr 5 with L=2.
  - `ready`=1 for one cycle, 2 edges after capture, with `data`=0xDEADBEEF.
- Back-to-back reads of addrs 0..7, pre-loaded with 0x100+i, master re-issuing immediately:
  - Eight responses, in order, each value correct.
  - Exactly L+1 cycles between `ready` pulses.
- Out of range, with RAM_DEPTH=200:
  - Read addr 250 → `data`=0 with normal latency.
  - Write to addr 210, then read addr 10 → that word is unchanged.
- Write collision, addr 3 holds 0x11:
  - Capture a read of addr 3, then write 0x22 to addr 3 on the next edge.
  - With BYPASS_EN, returns 0x22. Without, returns 0x11.
- Abort by reset, L=4:
  - Assert `n_rst` low 2 cycles after capture.
  - No `ready` follows; after release, a new read of addr 1 completes normally.
- Early `valid` drop:
  - Deassert `valid` 1 cycle after capture.
  - `ready` still pulses once at the normal time, and no second capture occurs.

Source files
------------

// File: rtl/r_bus_ram_responder.sv
// Read-port responder: serves word reads from an internal RAM after READ_LATENCY edges.
// Define R_BUS_RAM_RESPONDER_BYPASS_EN to forward in-flight writes to the captured address.
module r_bus_ram_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int RAM_DEPTH    = 256,
  parameter int READ_LATENCY = 2,
  localparam int LB_RAM_DEPTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    wr_en,
  input  logic [LB_RAM_DEPTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [LB_RAM_DEPTH-1:0] rd_addr,
  input  logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_ready
);

  localparam int AW = LB_RAM_DEPTH;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(RAM_DEPTH);
  localparam logic [1:0]  CNT_INIT = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] cap_word, hold_word;
  logic                  wr_ok;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  assign wr_ok = wr_en && in_range(wr_addr);

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

`ifdef R_BUS_RAM_RESPONDER_BYPASS_EN
  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (state_q == IDLE && rd_valid) addr_d = rd_addr;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  // Forwarding window spans the capture edge through the edge entering RESP.
  always_comb begin
    cap_word  = in_range(rd_addr) ? mem[rd_addr] : '0;
    hold_word = word_q;
    if (wr_ok && wr_addr == rd_addr) cap_word  = wr_data;
    if (wr_ok && wr_addr == addr_q)  hold_word = wr_data;
  end
`else
  always_comb begin
    cap_word  = in_range(rd_addr) ? mem[rd_addr] : '0;
    hold_word = word_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (rd_valid) begin
          if (READ_LATENCY == 1) begin
            state_d = RESP;
            data_d  = cap_word;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
            word_d  = cap_word;
          end
        end
      end
      WAIT: begin
        word_d = hold_word;
        if (cnt_q == '0) begin
          state_d = RESP;
          data_d  = hold_word;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
    end
  end

  assign rd_ready = (state_q == RESP);
  assign rd_data  = data_q;

endmodule

// File: tb/tb_r_bus_ram_responder.sv
// Bench for r_bus_ram_responder: two instances (L=2 and L=4, depth 200) against a RAM-array model.
module tb_r_bus_ram_responder;

  localparam int DEPTH = 200;
  localparam int LAT [2] = '{2, 4};

  logic            clk, n_rst;
  logic            wr_en;
  logic [7:0]      wr_addr;
  logic [31:0]     wr_data;
  logic [1:0]      v, rdy;
  logic [1:0][7:0]  ra;
  logic [1:0][31:0] rd;

  int errs = 0;
  int checks = 0;

  logic [31:0] ref_mem [256];
  bit          known [256];
  int          kq [$];

  r_bus_ram_responder #(.DATA_WIDTH(32), .RAM_DEPTH(DEPTH), .READ_LATENCY(2)) dut_a (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(ra[0]), .rd_valid(v[0]), .rd_data(rd[0]), .rd_ready(rdy[0]));

  r_bus_ram_responder #(.DATA_WIDTH(32), .RAM_DEPTH(DEPTH), .READ_LATENCY(4)) dut_b (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(ra[1]), .rd_valid(v[1]), .rd_data(rd[1]), .rd_ready(rdy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr(input int adr, input logic [31:0] dat);
    wr_en = 1'b1; wr_addr = 8'(adr); wr_data = dat;
    @(negedge clk);
    wr_en = 1'b0;
    if (adr < DEPTH) begin
      ref_mem[adr] = dat;
      if (!known[adr]) kq.push_back(adr);
      known[adr] = 1'b1;
    end
  endtask

  task automatic rdchk(input int s, input int adr, input logic [31:0] exp, input string tag);
    int n;
    v[s] = 1'b1; ra[s] = 8'(adr);
    @(negedge clk); n = 1;
    while (!rdy[s] && n < 20) begin @(negedge clk); n++; end
    v[s] = 1'b0;
    chk({tag, " latency"}, n, LAT[s]);
    chk({tag, " data"}, rd[s], exp);
    @(negedge clk);
    chk({tag, " ready one cycle"}, {31'd0, rdy[s]}, 32'd0);
    chk({tag, " data hold"}, rd[s], exp);
  endtask

  initial begin
    int idx, cyc, last, n, pulses, when_c, adr, s;
    logic [31:0] exp;
    n_rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; v = '0; ra = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end

    // Reset values
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset ready", {31'd0, rdy[k]}, 32'd0);
      chk("reset data", rd[k], 32'd0);
    end
    n_rst = 1'b1;
    @(negedge clk);

    // Write then read
    wr(5, 32'hDEADBEEF);
    rdchk(0, 5, ref_mem[5], "basic L2");
    rdchk(1, 5, ref_mem[5], "basic L4");

    // Back-to-back reads, master re-issuing on ready
    for (int i = 0; i < 8; i++) wr(i, 32'h100 + i);
    for (int k = 0; k < 2; k++) begin
      idx = 0; cyc = 0; last = 0;
      v[k] = 1'b1; ra[k] = 8'd0;
      while (idx < 8 && cyc < 200) begin
        @(negedge clk); cyc++;
        if (rdy[k]) begin
          chk("b2b data", rd[k], ref_mem[idx]);
          if (idx > 0) chk("b2b spacing", cyc - last, LAT[k] + 1);
          last = cyc; idx++; ra[k] = 8'(idx);
        end
      end
      v[k] = 1'b0;
      chk("b2b count", idx, 8);
      @(negedge clk);
    end

    // Out of range read and write
    for (int k = 0; k < 2; k++) rdchk(k, 250, 32'd0, "oor read");
    wr(10, 32'hA5A5_0010);
    wr(210, 32'hBAD0_0000);
    for (int k = 0; k < 2; k++) rdchk(k, 10, ref_mem[10], "oor write ignored");

    // Write collision one edge after capture
    for (int k = 0; k < 2; k++) begin
      wr(3, 32'h11);
      v[k] = 1'b1; ra[k] = 8'd3;
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'h22;
      @(negedge clk); n = 2;
      wr_en = 1'b0; ref_mem[3] = 32'h22;
      while (!rdy[k] && n < 20) begin @(negedge clk); n++; end
      v[k] = 1'b0;
`ifdef R_BUS_RAM_RESPONDER_BYPASS_EN
      exp = 32'h22;
`else
      exp = 32'h11;
`endif
      chk("collision latency", n, LAT[k]);
      chk("collision data", rd[k], exp);
      @(negedge clk);
      rdchk(k, 3, ref_mem[3], "after collision");
    end

    // Early valid drop: one response at normal time, no second capture
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b1; ra[k] = 8'd2;
      @(negedge clk);
      v[k] = 1'b0;
      pulses = rdy[k] ? 1 : 0; when_c = rdy[k] ? 1 : 0;
      for (int c = 2; c <= 14; c++) begin
        @(negedge clk);
        if (rdy[k]) begin
          pulses++;
          if (when_c == 0) begin when_c = c; chk("early drop data", rd[k], ref_mem[2]); end
        end
      end
      chk("early drop pulses", pulses, 1);
      chk("early drop time", when_c, LAT[k]);
    end

    // Reset two cycles after capture aborts the L=4 request
    v[1] = 1'b1; ra[1] = 8'd7;
    repeat (2) @(negedge clk);
    n_rst = 1'b0; v[1] = 1'b0;
    #1;
    chk("abort ready in reset", {31'd0, rdy[1]}, 32'd0);
    chk("abort data reset", rd[1], 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rdy[1] || rdy[0]) pulses++;
    end
    chk("abort no ready", pulses, 0);
    rdchk(1, 1, ref_mem[1], "after abort");

    // Randomized writes then reads against the reference array
    for (int i = 0; i < 40; i++) wr($urandom_range(0, 255), $urandom);
    for (int i = 0; i < 30; i++) begin
      s = i % 2;
      if ($urandom_range(0, 3) == 0) begin
        adr = $urandom_range(DEPTH, 255);
        rdchk(s, adr, 32'd0, "rand oor");
      end else begin
        adr = kq[$urandom_range(0, kq.size() - 1)];
        rdchk(s, adr, ref_mem[adr], "rand read");
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
